arbitro2_salida: RTL

//  Egress-side merge arbiter: reads the four per-destination output FIFOs
//  (filled by arbitro1) and forwards their words onto one downstream stream
//  (push/data) toward the egress FIFO.

---
 rtl/arbitro2_salida.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/arbitro2_salida.sv
// arbitro2_salida -- egress merge arbiter.
//
// Drains the four per-destination output FIFOs onto a single downstream
// push/data stream. One pop is issued per cycle at most. Source selection is
// round-robin by default. Define STRICT_PRIORITY_EN for fixed priority 0>1>2>3.
// In that build rr_ptr stays at 0.
// A pop issued at one edge returns valid data one edge later. That word is
// forwarded at the following edge, so at most two words are in flight.
// Grants stop while the downstream FIFO reports almost-full. Words already
// in flight still complete.
//
// Ports
//   clk, reset_L                   clock; synchronous active-low reset
//   fifo_empty0..3                 source FIFO empty flags
//   valid0..3, data_in0..3         source FIFO read data and its valid
//   fifo_af_out                    downstream almost-full
//   pop0..3                        registered read strobes (one-hot or zero)
//   data_out, push_out             registered forwarded word and write strobe
//   cont0..3                       words forwarded per source, modulo 32
//   idle                           IDLE state with no pop in the last 2 cycles
module arbitro2_salida #(
  parameter int DATA_SIZE = 12
) (
  input  logic                 clk,
  input  logic                 reset_L,
  input  logic                 fifo_empty0,
  input  logic                 fifo_empty1,
  input  logic                 fifo_empty2,
  input  logic                 fifo_empty3,
  input  logic                 valid0,
  input  logic                 valid1,
  input  logic                 valid2,
  input  logic                 valid3,
  input  logic [DATA_SIZE-1:0] data_in0,
  input  logic [DATA_SIZE-1:0] data_in1,
  input  logic [DATA_SIZE-1:0] data_in2,
  input  logic [DATA_SIZE-1:0] data_in3,
  input  logic                 fifo_af_out,
  output logic                 pop0,
  output logic                 pop1,
  output logic                 pop2,
  output logic                 pop3,
  output logic [DATA_SIZE-1:0] data_out,
  output logic                 push_out,
  output logic [4:0]           cont0,
  output logic [4:0]           cont1,
  output logic [4:0]           cont2,
  output logic [4:0]           cont3,
  output logic                 idle
);

  typedef enum logic [1:0] {
    S_RESET  = 2'd0,
    S_IDLE   = 2'd1,
    S_ACTIVE = 2'd2
  } state_t;

  state_t               state;
  logic [3:0]           empty_v, valid_v, pop_q;
  logic [DATA_SIZE-1:0] din [4];
  logic [3:0][4:0]      cont_q;
  logic [1:0]           rr_ptr, scan_idx, gnt, fwd_sel;
  logic                 gnt_ok, fwd_ok, pop_d;

  assign empty_v = {fifo_empty3, fifo_empty2, fifo_empty1, fifo_empty0};
  assign valid_v = {valid3, valid2, valid1, valid0};
  assign din[0]  = data_in0;
  assign din[1]  = data_in1;
  assign din[2]  = data_in2;
  assign din[3]  = data_in3;

  assign {pop3, pop2, pop1, pop0} = pop_q;
  assign cont0 = cont_q[0];
  assign cont1 = cont_q[1];
  assign cont2 = cont_q[2];
  assign cont3 = cont_q[3];

  // Scan from rr_ptr upward, wrapping mod 4. The loop runs from the farthest
  // offset down, so the nearest non-empty source wins. In strict-priority
  // builds rr_ptr never leaves 0, which gives the fixed 0>1>2>3 order.
  always_comb begin
    gnt_ok   = 1'b0;
    gnt      = rr_ptr;
    scan_idx = rr_ptr;
    for (int k = 3; k >= 0; k--) begin
      scan_idx = rr_ptr + 2'(k);
      if (!empty_v[scan_idx]) begin
        gnt_ok = 1'b1;
        gnt    = scan_idx;
      end
    end
  end

  // Only one valid should be high at a time. If several are, the lowest
  // index is forwarded and the rest are dropped.
  always_comb begin
    fwd_ok  = |valid_v;
    fwd_sel = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (valid_v[k]) fwd_sel = 2'(k);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      state    <= S_RESET;
      pop_q    <= '0;
      pop_d    <= 1'b0;
      push_out <= 1'b0;
      data_out <= '0;
      cont_q   <= '0;
      idle     <= 1'b0;
      rr_ptr   <= 2'd0;
    end else begin
      pop_q    <= '0;
      pop_d    <= |pop_q;
      push_out <= 1'b0;

      // Read data returning in the first cycle after reset belongs to a pop
      // issued before reset, so it is discarded.
      if (state != S_RESET && fwd_ok) begin
        push_out         <= 1'b1;
        data_out         <= din[fwd_sel];
        cont_q[fwd_sel]  <= cont_q[fwd_sel] + 5'd1;
      end

      case (state)
        S_RESET: begin
          state <= S_IDLE;
          idle  <= 1'b1;
        end
        S_IDLE: begin
          if (!(&empty_v) && !fifo_af_out) begin
            state <= S_ACTIVE;
            idle  <= 1'b0;
          end else begin
            idle  <= (pop_q == 4'd0) && !pop_d;
          end
        end
        S_ACTIVE: begin
          if (gnt_ok && !fifo_af_out) begin
            pop_q[gnt] <= 1'b1;
`ifndef STRICT_PRIORITY_EN
            rr_ptr     <= gnt + 2'd1;
`endif
            idle       <= 1'b0;
          end else if (pop_q == 4'd0 && valid_v == 4'd0) begin
            // Nothing left in flight, so it is safe to drop back to IDLE.
            state <= S_IDLE;
            idle  <= !pop_d;
          end else begin
            idle  <= 1'b0;
          end
        end
        default: begin
          state <= S_RESET;
          idle  <= 1'b0;
        end
      endcase
    end
  end

endmodule
